// File: rtl/dmem_resp_if.sv
// CPU data-port and dump-stream bundle for dmem_resp.
// Optional access counters exist only when DMEM_ACCESS_CNT_EN is defined.
interface dmem_resp_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128
);
    // CPU data port
    logic [0:ADDR_W-1] memAddr;
    logic [0:DATA_W-1] dataIn;
    logic              wrEn;
    logic              memEn;
    logic [0:DATA_W-1] dataOut;
    // dump stream
    logic              dump_start;
    logic              dump_busy;
    logic              dump_valid;
    logic [0:ADDR_W-1] dump_addr;
    logic [0:DATA_W-1] dump_data;
    logic              dump_done;
`ifdef DMEM_ACCESS_CNT_EN
    logic [0:15]       rd_count;
    logic [0:15]       wr_count;
`endif

    modport slave (
        input  memAddr, dataIn, wrEn, memEn, dump_start,
        output dataOut, dump_busy, dump_valid, dump_addr, dump_data, dump_done
`ifdef DMEM_ACCESS_CNT_EN
        , output rd_count, wr_count
`endif
    );

    modport master (
        output memAddr, dataIn, wrEn, memEn, dump_start,
        input  dataOut, dump_busy, dump_valid, dump_addr, dump_data, dump_done
`ifdef DMEM_ACCESS_CNT_EN
        , input rd_count, wr_count
`endif
    );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: CPU load/store into a DEPTH x DATA_W array plus a
// dump sequencer that streams the first DUMP_DEPTH words on idle CPU cycles.
// Optional feature macro: DMEM_ACCESS_CNT_EN (saturating load/store counters).
module dmem_resp #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 128,
    parameter int DUMP_DEPTH = 128
) (
    input logic         clk,
    input logic         reset,
    dmem_resp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [0:ADDR_W-1] LAST_PTR = ADDR_W'(DUMP_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state_q, state_d;
    logic [0:ADDR_W-1] ptr_q, ptr_d;
    logic              issue;

    logic [0:DATA_W-1] mem [DEPTH];

    logic [0:DATA_W-1] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;
    logic [0:ADDR_W-1] daddr_q, daddr_d;
    logic [0:DATA_W-1] ddata_q, ddata_d;
    logic              ddone_q, ddone_d;

    logic cpu_rd, cpu_wr;

    assign cpu_rd = bus.memEn & ~bus.wrEn;
    assign cpu_wr = bus.memEn & bus.wrEn;

    // State register and scan pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: scan advances only on cycles the CPU leaves the array free
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: if (bus.dump_start) begin
                state_d = SCAN;
                ptr_d   = '0;
            end
            SCAN: if (!bus.memEn) begin
                if (ptr_q == LAST_PTR) state_d = DONE;
                else                   ptr_d   = ptr_q + ADDR_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: dump read issue and the done pulse leaving DONE
    always_comb begin
        issue   = (state_q == SCAN) && !bus.memEn;
        ddone_d = (state_q == DONE);
    end

    // Datapath next values; everything holds unless its access occurs
    always_comb begin
        dout_d   = cpu_rd ? mem[bus.memAddr] : dout_q;
        dvalid_d = issue;
        daddr_d  = issue ? ptr_q : daddr_q;
        ddata_d  = issue ? mem[ptr_q] : ddata_q;
    end

    // Output registers; contents of the array survive reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            daddr_q  <= '0;
            ddata_q  <= '0;
            ddone_q  <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            daddr_q  <= daddr_d;
            ddata_q  <= ddata_d;
            ddone_q  <= ddone_d;
        end
    end

    // Storage array write port; reads above see pre-edge contents
    always_ff @(posedge clk) begin
        if (cpu_wr) mem[bus.memAddr] <= bus.dataIn;
    end

    assign bus.dataOut    = dout_q;
    assign bus.dump_busy  = (state_q != IDLE);
    assign bus.dump_valid = dvalid_q;
    assign bus.dump_addr  = daddr_q;
    assign bus.dump_data  = ddata_q;
    assign bus.dump_done  = ddone_q;

`ifdef DMEM_ACCESS_CNT_EN
    logic [0:15] rdc_q, rdc_d, wrc_q, wrc_d;

    // Saturating CPU access counters; dump reads are not counted
    always_comb begin
        rdc_d = (cpu_rd && rdc_q != 16'hFFFF) ? rdc_q + 16'd1 : rdc_q;
        wrc_d = (cpu_wr && wrc_q != 16'hFFFF) ? wrc_q + 16'd1 : wrc_q;
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdc_q <= '0;
            wrc_q <= '0;
        end else begin
            rdc_q <= rdc_d;
            wrc_q <= wrc_d;
        end
    end

    assign bus.rd_count = rdc_q;
    assign bus.wr_count = wrc_q;
`endif
endmodule
